sn_dispatch: RTL and testbench

SN_DISPATCH -- requirements
Module: sn_dispatch

---
 rtl/sn_dispatch_pkg.sv | 22 ++
 rtl/sn_dispatch_rr_pick.sv | 45 ++++
 rtl/sn_dispatch.sv | 127 ++++++++++++
 tb/tb_sn_dispatch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_dispatch_pkg.sv
// rtl/sn_dispatch_pkg.sv - shared types and constants for the snooper dispatcher
// Optional feature macro: SN_DISPATCH_DROP_EN (adds the DROP state).
package sn_dispatch_pkg;

    localparam int N_CORES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLAIM  = 2'd1,
        ST_STREAM = 2'd2
`ifdef SN_DISPATCH_DROP_EN
        ,
        ST_DROP   = 2'd3
`endif
    } state_t;

    // Width of a core index; at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sn_dispatch_rr_pick.sv
// rtl/sn_dispatch_rr_pick.sv - combinational round-robin picker
// Ports:
//   i_req       : request vector, one bit per core
//   i_last      : index of the core served last
//   o_grant     : first requesting index searching from i_last+1 (mod N)
//   o_any_valid : at least one request present
import sn_dispatch_pkg::*;

module rr_pick #(
    parameter int N  = N_CORES_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_grant,
    output logic          o_any_valid
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic          w_found;

    assign o_any_valid = |i_req;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        // One spare bit holds last+i before the modulo wrap; i runs 1..N so
        // the search ends on i_last itself (same core reselected last).
        for (int i = 1; i <= N; i++) begin
            w_sum = {1'b0, i_last} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sn_dispatch.sv
// rtl/sn_dispatch.sv - routes one snooper write stream to one of N packet-memory cores
// Optional feature macro: SN_DISPATCH_DROP_EN (drop packets when no core is free, drop_cnt port).
// Ports:
//   clk, rst (sync, active-low)
//   sn_*            : upstream write stream in, sn_rdy out while a core is claimed
//   core_sn_*       : data broadcast to all cores, per-core wr_en/done strobes
//   core_rdy_for_sn : per-core buffer-free flags; core_rdy_for_sn_ack claims one
//   drop_cnt        : saturating dropped-packet count (feature build only)
import sn_dispatch_pkg::*;

module sn_dispatch #(
    parameter int N_CORES            = N_CORES_DEF,
    parameter int PACKMEM_ADDR_WIDTH = 9,
    parameter int PACKMEM_DATA_WIDTH = 64,
    parameter int INC_WIDTH          = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PACKMEM_ADDR_WIDTH-1:0] sn_addr,
    input  logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data,
    input  logic [INC_WIDTH-1:0]          sn_byte_inc,
    input  logic                          sn_wr_en,
    input  logic                          sn_done,
    output logic                          sn_rdy,
    output logic [PACKMEM_ADDR_WIDTH-1:0] core_sn_addr,
    output logic [PACKMEM_DATA_WIDTH-1:0] core_sn_wr_data,
    output logic [INC_WIDTH-1:0]          core_sn_byte_inc,
    output logic [N_CORES-1:0]            core_sn_wr_en,
    output logic [N_CORES-1:0]            core_sn_done,
    output logic [N_CORES-1:0]            core_rdy_for_sn_ack,
`ifdef SN_DISPATCH_DROP_EN
    output logic [31:0]                   drop_cnt,
`endif
    input  logic [N_CORES-1:0]            core_rdy_for_sn
);

    localparam int IW = idx_w(N_CORES);

    state_t             r_state;
    logic [IW-1:0]      r_sel;
    logic [IW-1:0]      r_last;
    logic [N_CORES-1:0] r_ack;
    logic               r_sn_rdy;
    logic [IW-1:0]      w_grant;
    logic               w_any;
    logic [N_CORES-1:0] w_onehot;
`ifdef SN_DISPATCH_DROP_EN
    logic [31:0]        r_drop_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

    rr_pick #(.N(N_CORES), .IW(IW)) u_rr_pick (
        .i_req       (core_rdy_for_sn),
        .i_last      (r_last),
        .o_grant     (w_grant),
        .o_any_valid (w_any)
    );

    assign core_sn_addr     = sn_addr;
    assign core_sn_wr_data  = sn_wr_data;
    assign core_sn_byte_inc = sn_byte_inc;

    // r_sn_rdy is high exactly in STREAM, so it gates the per-core strobes.
    assign w_onehot            = r_sn_rdy ? (N_CORES'(1) << r_sel) : '0;
    assign core_sn_wr_en       = w_onehot & {N_CORES{sn_wr_en}};
    assign core_sn_done        = w_onehot & {N_CORES{sn_done}};
    assign core_rdy_for_sn_ack = r_ack;
    assign sn_rdy              = r_sn_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_last     <= IW'(N_CORES - 1);
            r_ack      <= '0;
            r_sn_rdy   <= 1'b0;
`ifdef SN_DISPATCH_DROP_EN
            r_drop_cnt <= '0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_grant;
                        r_ack   <= N_CORES'(1) << w_grant;
                        r_state <= ST_CLAIM;
                    end
`ifdef SN_DISPATCH_DROP_EN
                    else if (sn_wr_en) begin
                        // A one-write packet is dropped and counted on the spot.
                        if (sn_done) begin
                            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
`endif
                end
                ST_CLAIM: begin
                    r_sn_rdy <= 1'b1;
                    r_state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (sn_done) begin
                        r_last   <= r_sel;
                        r_sn_rdy <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
`ifdef SN_DISPATCH_DROP_EN
                ST_DROP: begin
                    if (sn_done) begin
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_sn_rdy <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_dispatch.sv
// tb/tb_sn_dispatch.sv - self-checking bench for sn_dispatch
module tb_sn_dispatch;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  sn_addr;
    logic [63:0] sn_wr_data;
    logic [7:0]  sn_byte_inc;
    logic        sn_wr_en;
    logic        sn_done;
    logic        sn_rdy;
    logic [8:0]  core_sn_addr;
    logic [63:0] core_sn_wr_data;
    logic [7:0]  core_sn_byte_inc;
    logic [3:0]  core_sn_wr_en;
    logic [3:0]  core_sn_done;
    logic [3:0]  core_rdy_for_sn_ack;
    logic [3:0]  core_rdy_for_sn;
`ifdef SN_DISPATCH_DROP_EN
    logic [31:0] drop_cnt;
`endif

    sn_dispatch dut (
        .clk                 (clk),
        .rst                 (rst),
        .sn_addr             (sn_addr),
        .sn_wr_data          (sn_wr_data),
        .sn_byte_inc         (sn_byte_inc),
        .sn_wr_en            (sn_wr_en),
        .sn_done             (sn_done),
        .sn_rdy              (sn_rdy),
        .core_sn_addr        (core_sn_addr),
        .core_sn_wr_data     (core_sn_wr_data),
        .core_sn_byte_inc    (core_sn_byte_inc),
        .core_sn_wr_en       (core_sn_wr_en),
        .core_sn_done        (core_sn_done),
        .core_rdy_for_sn_ack (core_rdy_for_sn_ack),
`ifdef SN_DISPATCH_DROP_EN
        .drop_cnt            (drop_cnt),
`endif
        .core_rdy_for_sn     (core_rdy_for_sn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = no core owned, 1 = claim announced,
    // 2 = streaming to m_sel, 3 = discarding a packet.
    int m_phase;
    int m_sel;
    int m_last;
    int m_drop;

    logic [3:0] s_ack, s_wr, s_done;
    logic       s_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_sel   = 0;
        m_last  = N - 1;
        m_drop  = 0;
    endtask

    task automatic step(input logic r, input logic [3:0] rdy, input logic wr, input logic dn);
        logic [3:0] e_ack, e_wr, e_done;
        bit found;
        @(negedge clk);
        rst             = r;
        core_rdy_for_sn = rdy;
        sn_wr_en        = wr;
        sn_done         = dn;
        sn_addr         = 9'($urandom);
        sn_wr_data      = {$urandom, $urandom};
        sn_byte_inc     = 8'($urandom);
        #1;
        e_ack  = (m_phase == 1) ? 4'(1 << m_sel) : 4'b0;
        e_wr   = (m_phase == 2 && wr) ? 4'(1 << m_sel) : 4'b0;
        e_done = (m_phase == 2 && dn) ? 4'(1 << m_sel) : 4'b0;
        s_ack  = core_rdy_for_sn_ack;
        s_wr   = core_sn_wr_en;
        s_done = core_sn_done;
        s_rdy  = sn_rdy;
        chk("model_ack",   64'(core_rdy_for_sn_ack), 64'(e_ack));
        chk("model_wr_en", 64'(core_sn_wr_en),       64'(e_wr));
        chk("model_done",  64'(core_sn_done),        64'(e_done));
        chk("model_rdy",   64'(sn_rdy),              64'(m_phase == 2));
        chk("bcast_addr",  64'(core_sn_addr),        64'(sn_addr));
        chk("bcast_data",  core_sn_wr_data,          sn_wr_data);
        chk("bcast_inc",   64'(core_sn_byte_inc),    64'(sn_byte_inc));
`ifdef SN_DISPATCH_DROP_EN
        chk("model_drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_last + k) % N;
                        if (!found && rdy[c]) begin
                            m_sel = c;
                            found = 1'b1;
                        end
                    end
                    if (found) m_phase = 1;
`ifdef SN_DISPATCH_DROP_EN
                    else if (wr) begin
                        if (dn) m_drop = m_drop + 1;
                        else    m_phase = 3;
                    end
`endif
                end
                1: m_phase = 2;
                2: if (dn) begin
                    m_last  = m_sel;
                    m_phase = 0;
                end
                default: if (dn) begin
                    m_drop  = m_drop + 1;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    typedef struct {
        logic [3:0] rdy;
        logic       wr;
        logic       dn;
        logic [3:0] e_ack;
        logic       e_rdy;
        logic [3:0] e_wr;
        logic [3:0] e_done;
    } vec_t;

    vec_t tbl[15];

    initial begin
        rst = 1'b0; core_rdy_for_sn = '0; sn_wr_en = 1'b0; sn_done = 1'b0;
        sn_addr = '0; sn_wr_data = '0; sn_byte_inc = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Basic claim/stream/back-to-back sequence; rdy drops after selection.
        tbl[0] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[1] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        for (int i = 2; i <= 9; i++)
            tbl[i] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000};
        tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0001};
        tbl[11] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0010, 4'b0010};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};

        // Post-reset idle outputs.
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("reset_ack", 64'(s_ack), 64'h0);
        chk("reset_rdy", 64'(s_rdy), 64'h0);
        chk("reset_wr",  64'(s_wr),  64'h0);
`ifdef SN_DISPATCH_DROP_EN
        chk("reset_drop_cnt", 64'(drop_cnt), 64'h0);
`endif

        for (int i = 0; i < 15; i++) begin
            step(1'b1, tbl[i].rdy, tbl[i].wr, tbl[i].dn);
            chk($sformatf("tbl%0d_ack", i),  64'(s_ack),  64'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_rdy", i),  64'(s_rdy),  64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_wr", i),   64'(s_wr),   64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_done", i), 64'(s_done), 64'(tbl[i].e_done));
        end

        // Wrap-around: only core 3 ready with last=3, twice in a row.
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("wrap_ack1", 64'(s_ack), 64'h8);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 1'b1);
        chk("wrap_done", 64'(s_done), 64'h8);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("wrap_ack2", 64'(s_ack), 64'h8);

        // Reset during the third write of a packet to core 2.
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("mid_ack", 64'(s_ack), 64'h4);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("mid_wr3", 64'(s_wr), 64'h4);
        step(1'b1, 4'b1111, 1'b1, 1'b1);
        chk("mid_rst_rdy",  64'(s_rdy),  64'h0);
        chk("mid_rst_wr",   64'(s_wr),   64'h0);
        chk("mid_rst_done", 64'(s_done), 64'h0);
        chk("mid_rst_ack",  64'(s_ack),  64'h0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("mid_reclaim_ack", 64'(s_ack), 64'h1);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0);

`ifdef SN_DISPATCH_DROP_EN
        // No core ready: five writes then sn_done are discarded and counted.
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        chk("drop_cnt_start", 64'(drop_cnt), 64'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0000, 1'b1, 1'b0);
            chk("drop_wr", 64'(s_wr), 64'h0);
        end
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("drop_done", 64'(s_done), 64'h0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("drop_cnt_end", 64'(drop_cnt), 64'h1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) != 0,
                 ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000,
                 1'($urandom),
                 ($urandom % 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
